// File: rtl/la_capture_core.sv
// la_capture_core
//   Parametrised logic-analyzer capture engine. Probe inputs are synchronised,
//   decimated by a programmable divider and written into a circular buffer.
//   A masked pattern / edge / immediate trigger ends the pre-trigger phase.
//   The buffer is then filled with post-trigger samples and offered for
//   oldest-first readout over a valid/pop interface.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for arm, no writes, rd_valid low
//   ARMED | writing every strobe, pre-fill counting, trigger qualified once
//         | PRE samples are held
//   POST  | writing post-trigger samples until the buffer holds one capture
//   DONE  | rd_valid high, rd_en pops oldest-first, last pop returns to IDLE
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   ch_in[CH]             asynchronous probe inputs
//   arm, abort            start capture / return to IDLE from any state
//   trig_mode[2]          00 immediate, 01 pattern, 10 rising, 11 falling
//   trig_mask, trig_value channels participating / pattern value
//   sample_div[DIV_W]     sample every sample_div+1 clocks
//   rd_en                 pop one sample while rd_valid
//   rd_data, rd_valid     sample at the read pointer / capture available
//   state[2], triggered   FSM state / trigger fired in this capture

module la_capture_core #(
    parameter int CH    = 8,
    parameter int DEPTH = 64,
    parameter int PRE   = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    ch_in,
    input  logic             arm,
    input  logic             abort,
    input  logic [1:0]       trig_mode,
    input  logic [CH-1:0]    trig_mask,
    input  logic [CH-1:0]    trig_value,
    input  logic [DIV_W-1:0] sample_div,
    input  logic             rd_en,
    output logic [CH-1:0]    rd_data,
    output logic             rd_valid,
    output logic [1:0]       state,
    output logic             triggered
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int POST_LEN = DEPTH - PRE - 1;

    localparam logic [AW-1:0] PRE_N     = AW'(PRE);
    localparam logic [CW-1:0] POST_INIT = CW'(POST_LEN);
    localparam logic [CW-1:0] RD_INIT   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CH-1:0]    sync1_q, sync2_q;
    logic [CH-1:0]    prev_q, prev_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    trig_ptr_q, trig_ptr_d;
    logic [AW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]    post_cnt_q, post_cnt_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic             triggered_q, triggered_d;
    logic             rd_valid_q, rd_valid_d;

    logic [CH-1:0]    mem_q [DEPTH];
    logic             wr_en;
    logic             strobe;
    logic             trig_hit;
    logic [CH-1:0]    smp;

    assign smp    = sync2_q;
    assign strobe = (div_cnt_q == sample_div);

    always_comb begin
        case (trig_mode)
            2'b00:   trig_hit = 1'b1;
            2'b01:   trig_hit = (((smp ^ trig_value) & trig_mask) == '0);
            2'b10:   trig_hit = |(~prev_q & smp & trig_mask);
            default: trig_hit = |(prev_q & ~smp & trig_mask);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        div_cnt_d   = strobe ? '0 : div_cnt_q + 1'b1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_ptr_d  = trig_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        triggered_d = triggered_q;
        rd_valid_d  = rd_valid_q;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d     = S_ARMED;
                    wr_ptr_d    = '0;
                    pre_cnt_d   = '0;
                    triggered_d = 1'b0;
                    prev_d      = smp;
                    div_cnt_d   = '0;
                end
            end
            S_ARMED: begin
                if (strobe) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    prev_d   = smp;
                    if ((pre_cnt_q == PRE_N) && trig_hit) begin
                        trig_ptr_d  = wr_ptr_q;
                        post_cnt_d  = POST_INIT;
                        triggered_d = 1'b1;
                        // With no post-trigger samples the capture is already complete.
                        if (POST_LEN == 0) begin
                            state_d    = S_DONE;
                            rd_ptr_d   = wr_ptr_q - PRE_N;
                            rd_cnt_d   = RD_INIT;
                            rd_valid_d = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end else if (pre_cnt_q != PRE_N) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end
            end
            S_POST: begin
                if (strobe) begin
                    wr_en      = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    prev_d     = smp;
                    post_cnt_d = post_cnt_q - CNT_ONE;
                    if (post_cnt_q == CNT_ONE) begin
                        state_d    = S_DONE;
                        rd_ptr_d   = trig_ptr_q - PRE_N;
                        rd_cnt_d   = RD_INIT;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rd_cnt_d = rd_cnt_q - CNT_ONE;
                    if (rd_cnt_q == CNT_ONE) begin
                        state_d    = S_IDLE;
                        rd_valid_d = 1'b0;
                    end
                end
            end
        endcase

        // abort dominates everything, including a simultaneous arm
        if (abort) begin
            state_d     = S_IDLE;
            rd_valid_d  = 1'b0;
            triggered_d = 1'b0;
            wr_en       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            div_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= ch_in;
            sync2_q     <= sync1_q;
            prev_q      <= prev_d;
            div_cnt_q   <= div_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_ptr_q  <= trig_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Sample storage carries no reset; contents are only exposed in DONE.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= smp;
        end
    end

    assign rd_data   = rd_valid_q ? mem_q[rd_ptr_q] : '0;
    assign rd_valid  = rd_valid_q;
    assign state     = state_q;
    assign triggered = triggered_q;

endmodule

// File: tb/tb_la_capture_core.sv
module tb_la_capture_core;

    localparam int CH    = 8;
    localparam int DEPTH = 16;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    ch_in = '0;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       trig_mode = 2'b00;
    logic [CH-1:0]    trig_mask = '0;
    logic [CH-1:0]    trig_value = '0;
    logic [DIV_W-1:0] sample_div = '0;
    logic [2:0]       rde = '0;

    logic [CH-1:0] rdd0, rdd1, rdd2;
    logic [1:0]    st0, st1, st2;
    logic          rdv0, rdv1, rdv2, trg0, trg1, trg2;

    logic [2:0][CH-1:0] rdd;
    logic [2:0][1:0]    st;
    logic [2:0]         rdv, trg;
    assign rdd = {rdd2, rdd1, rdd0};
    assign st  = {st2, st1, st0};
    assign rdv = {rdv2, rdv1, rdv0};
    assign trg = {trg2, trg1, trg0};

    always #5 clk = ~clk;

    // three builds: PRE=4, PRE=0, PRE=DEPTH-1, all sharing stimulus
    la_capture_core #(.CH(CH), .DEPTH(DEPTH), .PRE(4), .DIV_W(DIV_W)) u0 (
        .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
        .sample_div(sample_div), .rd_en(rde[0]), .rd_data(rdd0), .rd_valid(rdv0),
        .state(st0), .triggered(trg0));
    la_capture_core #(.CH(CH), .DEPTH(DEPTH), .PRE(0), .DIV_W(DIV_W)) u1 (
        .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
        .sample_div(sample_div), .rd_en(rde[1]), .rd_data(rdd1), .rd_valid(rdv1),
        .state(st1), .triggered(trg1));
    la_capture_core #(.CH(CH), .DEPTH(DEPTH), .PRE(DEPTH-1), .DIV_W(DIV_W)) u2 (
        .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
        .sample_div(sample_div), .rd_en(rde[2]), .rd_data(rdd2), .rd_valid(rdv2),
        .state(st2), .triggered(trg2));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int base = 0;
    int kind = 0;
    logic [7:0] hist [0:8191];
    int   post_cyc [3];
    int   done_cyc [3];
    logic trg_post [3];
    logic trg_done [3];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    function automatic int pre_of(input int d);
        case (d)
            0:       return 4;
            1:       return 0;
            default: return DEPTH - 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ch_in value for the edge numbered n; k counts edges from base (= t0-2)
    function automatic logic [7:0] gen(input int n);
        int k;
        logic [7:0] r;
        k = n - base;
        r = 8'($urandom);
        case (kind)
            1:       return (k == 10) ? 8'hA5 : 8'(k - 1);
            2:       return {r[7:1], ((k >= 2 && k <= 8) || k >= 10)};
            3:       return 8'(k);
            default: return r;
        endcase
    endfunction

    task automatic cycle(input logic [7:0] v);
        ch_in = v;
        hist[cyc+1] = v;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (post_cyc[i] < 0 && st[i] == 2'b10) begin
                post_cyc[i] = cyc;
                trg_post[i] = trg[i];
            end
            if (done_cyc[i] < 0 && st[i] == 2'b11) begin
                done_cyc[i] = cyc;
                trg_done[i] = trg[i];
            end
        end
    endtask

    task automatic step();
        cycle(gen(cyc + 1));
    endtask

    task automatic start_capture();
        abort = 1'b1;
        step();
        abort = 1'b0;
        base = cyc + 1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            post_cyc[i] = -1;
            done_cyc[i] = -1;
            trg_post[i] = 1'b0;
            trg_done[i] = 1'b0;
        end
        arm = 1'b1;
        step();
        arm = 1'b0;
        t0 = cyc;
    endtask

    function automatic bit fires(input logic [7:0] s, input logic [7:0] p);
        bit all_eq, any_rise, any_fall;
        all_eq = 1; any_rise = 0; any_fall = 0;
        for (int i = 0; i < CH; i++) begin
            if (trig_mask[i]) begin
                if (s[i] != trig_value[i]) all_eq = 0;
                if (!p[i] && s[i]) any_rise = 1;
                if (p[i] && !s[i]) any_fall = 1;
            end
        end
        case (trig_mode)
            2'b00:   return 1;
            2'b01:   return all_eq;
            2'b10:   return any_rise;
            default: return any_fall;
        endcase
    endfunction

    // Strobe m (m>=1) lands on edge t0+m*sp and stores the input driven two
    // edges earlier; "strobe 0" is the value loaded into prev at arm.
    task automatic predict(input int d, output int te, output int de);
        int pre, pl, sp;
        pre = pre_of(d);
        pl  = DEPTH - pre - 1;
        sp  = int'(sample_div) + 1;
        exp_q.delete();
        te = -1;
        de = -1;
        for (int m = 1; t0 + m*sp - 2 <= cyc; m++) begin
            if (m - 1 >= pre && fires(hist[t0 + m*sp - 2], hist[t0 + (m-1)*sp - 2])) begin
                te = t0 + m*sp;
                de = t0 + (m + pl)*sp;
                for (int j = m - pre; j <= m + pl; j++) exp_q.push_back(hist[t0 + j*sp - 2]);
                break;
            end
        end
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (st[d] != 2'b11 && n < 400) begin
            step();
            n++;
        end
        chk("reach_done", st[d], 2'b11);
    endtask

    task automatic pops(input int d, input int n);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : 8'hxx;
            chk("rd_valid_during_read", rdv[d], 1'b1);
            chk("rd_data", rdd[d], e);
            got_q.push_back(rdd[d]);
            rde[d] = 1'b1;
            step();
            rde[d] = 1'b0;
        end
    endtask

    task automatic full_check(input int d);
        int te, de;
        wait_done(d);
        predict(d, te, de);
        chk("model_capture_len", exp_q.size(), DEPTH);
        chk("done_edge", done_cyc[d], de);
        if (pre_of(d) == DEPTH - 1) begin
            chk("direct_done_no_post", post_cyc[d], -1);
            chk("triggered_at_done", trg_done[d], 1'b1);
        end else begin
            chk("trig_edge", post_cyc[d], te);
            chk("triggered_at_post", trg_post[d], 1'b1);
        end
        chk("rd_valid_done", rdv[d], 1'b1);
        step();
        chk("hold_without_pop", rdd[d], (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
        got_q.delete();
        pops(d, DEPTH);
        chk("rd_valid_after_drain", rdv[d], 1'b0);
        chk("idle_after_drain", st[d], 2'b00);
    endtask

    initial begin
        int te, de, n;
        for (int i = 0; i < 3; i++) begin
            post_cyc[i] = -1;
            done_cyc[i] = -1;
        end
        repeat (3) step();
        chk("reset_state", st[0], 2'b00);
        chk("reset_rd_valid", rdv[0], 1'b0);
        chk("reset_triggered", trg[0], 1'b0);
        chk("reset_rd_data", rdd[0], 8'h00);
        rst_n = 1'b1;

        // pattern A5 on a counting input
        sample_div = 0; trig_mode = 2'b01; trig_mask = 8'hFF; trig_value = 8'hA5; kind = 1;
        start_capture();
        chk("armed_after_arm", st[0], 2'b01);
        full_check(0);
        chk("pattern_trig_abs", post_cyc[0], t0 + 10);
        chk("pattern_first_pop", got_q[0], 8'd5);
        chk("pattern_trig_pop", got_q[4], 8'hA5);
        chk("pattern_last_pop", got_q[15], 8'd20);

        // rising edge on ch0: early rise and hold ignored, later rise fires
        trig_mode = 2'b10; trig_mask = 8'h01; kind = 2;
        start_capture();
        full_check(0);
        chk("rise_trig_abs", post_cyc[0], t0 + 10);

        // divider of 4 with a counting input
        trig_mode = 2'b00; sample_div = 3; kind = 3;
        start_capture();
        full_check(0);
        chk("div_trig_to_done", done_cyc[0] - post_cyc[0], (DEPTH - 4 - 1) * 4);
        chk("div_sample_spacing", 8'(got_q[1] - got_q[0]), 8'd4);

        // edge mode with empty mask never fires
        trig_mode = 2'b10; trig_mask = 8'h00; sample_div = 0; kind = 0;
        start_capture();
        repeat (40) step();
        chk("edge_mask0_armed", st[0], 2'b01);
        chk("edge_mask0_not_trig", trg[0], 1'b0);

        // pattern mode with empty mask fires as soon as pre-fill completes
        trig_mode = 2'b01; trig_value = 8'($urandom);
        start_capture();
        full_check(0);
        chk("pattern_mask0_abs", post_cyc[0], t0 + 5);

        // random edge captures
        for (int r = 0; r < 3; r++) begin
            trig_mode  = (r == 1) ? 2'b10 : 2'b11;
            trig_mask  = 8'($urandom) | 8'h01;
            sample_div = 8'($urandom_range(0, 2));
            start_capture();
            full_check(0);
        end

        // immediate trigger across PRE=4, PRE=0, PRE=DEPTH-1
        trig_mode = 2'b00; sample_div = 0; kind = 0;
        start_capture();
        full_check(1);
        chk("pre0_first_pop", got_q[0], hist[t0 - 1]);
        full_check(2);
        full_check(0);

        // abort during POST
        sample_div = 1;
        start_capture();
        n = 0;
        while (st[0] != 2'b10 && n < 100) begin step(); n++; end
        chk("reach_post", st[0], 2'b10);
        step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_post_state", st[0], 2'b00);
        chk("abort_post_valid", rdv[0], 1'b0);
        chk("abort_post_trig", trg[0], 1'b0);

        // abort after three pops
        sample_div = 0;
        start_capture();
        wait_done(0);
        predict(0, te, de);
        got_q.delete();
        pops(0, 3);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_done_state", st[0], 2'b00);
        chk("abort_done_valid", rdv[0], 1'b0);
        chk("abort_done_trig", trg[0], 1'b0);

        // abort together with arm keeps IDLE
        abort = 1'b1; arm = 1'b1; step();
        abort = 1'b0; arm = 1'b0;
        chk("abort_arm_idle", st[0], 2'b00);
        step();
        chk("abort_arm_still_idle", st[0], 2'b00);

        // asynchronous reset mid-POST, then a fresh capture
        sample_div = 2;
        start_capture();
        n = 0;
        while (st[0] != 2'b10 && n < 100) begin step(); n++; end
        chk("reach_post_rst", st[0], 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_state", st[0], 2'b00);
        chk("rst_valid", rdv[0], 1'b0);
        chk("rst_trig", trg[0], 1'b0);
        chk("rst_data", rdd[0], 8'h00);
        step();
        step();
        rst_n = 1'b1;
        trig_mode = 2'b10; trig_mask = 8'hFF; sample_div = 0; kind = 0;
        start_capture();
        full_check(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
Parametrised capture engine for the logic analyzer. It replaces the fixed 4-channel raw/trigger capture with N channels and a configurable-depth circular sample buffer. It supports pre-trigger history, masked pattern/edge triggers and a programmable sample-rate divider. Captured samples are read out oldest-first over a valid/ready-style pop interface; the top-level mode mux and replay logic consume this interface.

Parameters:
CH, 8, number of input channels (sample width), 1..16
DEPTH, 64, buffer depth in samples; power of 2, 4..256
PRE, 16, pre-trigger samples kept; 0 <= PRE < DEPTH
DIV_W, 8, width of sample_div

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_in  in  CH  asynchronous probe inputs
arm  in  1  start capture (level sampled each cycle)
abort  in  1  return to IDLE from any state
trig_mode  in  2  00 immediate, 01 pattern, 10 rising edge, 11 falling edge
trig_mask  in  CH  channels participating in the trigger
trig_value  in  CH  pattern value (mode 01 only)
sample_div  in  DIV_W  sample every sample_div+1 clocks
rd_en  in  1  pop one sample (honoured only while rd_valid)
rd_data  out  CH  sample at read pointer
rd_valid  out  1  buffer holds unread capture data
state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
triggered  out  1  trigger has fired in the current capture

Behaviour:
- Reset: state=IDLE; rd_valid=0; triggered=0; rd_data=0; all pointers, counters and synchronizer flops=0. Buffer contents are don't-care.
- ch_in passes through a 2-flop synchronizer. Sample s = synchronized value. prev = s at the previous strobe.
- Divider: div_cnt counts 0..sample_div. strobe=1 when div_cnt==sample_div, then div_cnt wraps to 0. sample_div=0 gives a strobe every cycle. div_cnt clears on the IDLE->ARMED transition.
- Trigger condition, evaluated on strobe only:
  - pattern: ((s ^ trig_value) & trig_mask)==0
  - rising: |(~prev & s & trig_mask)
  - falling: |(prev & ~s & trig_mask)
  - immediate: always true
  - trig_mask=0 in edge modes never fires. trig_mask=0 in pattern mode always fires.
- Transitions:
  - IDLE: arm=1 -> ARMED. wr_ptr=0, pre_cnt=0, triggered=0, prev loaded with the current s.
  - ARMED: each strobe writes s to mem[wr_ptr] and increments wr_ptr (mod DEPTH). pre_cnt saturates at PRE. The trigger is ignored until pre_cnt==PRE before the strobe. On a qualifying strobe: the trigger sample is written, trig_ptr=wr_ptr, post_cnt=DEPTH-PRE-1, triggered=1 -> POST. If DEPTH-PRE-1==0 the next state is DONE directly.
  - POST: each strobe writes a sample and decrements post_cnt. The write that makes post_cnt==0 -> DONE. rd_ptr=(trig_ptr-PRE) mod DEPTH, rd_cnt=DEPTH.
  - DONE: rd_valid=1, and rd_data=mem[rd_ptr] combinationally from the pointer. rd_en pops: rd_ptr++, rd_cnt--. The pop with rd_cnt==1 -> IDLE with rd_valid=0 on the next cycle. Sample order is oldest first: PRE pre-trigger samples, then the trigger sample, then the post-trigger samples.
- No writes occur in IDLE or DONE.
- rd_en outside DONE is ignored.
- arm while in ARMED, POST or DONE is ignored. The host must drain the buffer or abort first.
- abort=1 -> IDLE next cycle from any state, with rd_valid=0 and triggered=0. When abort and arm are asserted together, abort wins (a later arm is needed).
- Asynchronous reset mid-capture or mid-readout returns to the reset values immediately. No partial data is presented.
- Arithmetic: pointers are log2(DEPTH) bits and wrap naturally. post_cnt and rd_cnt are log2(DEPTH)+1 bits.

Test Plan:
- CH=8, DEPTH=16, PRE=4, div=0, mode 01, mask=FF, value=A5. Drive count 0,1,2,... with A5 at sample 9 -> state 01->10->11. 16 pops return samples 5..8, A5, then the 11 following samples. rd_valid drops after the 16th pop.
- Mode 10, mask=01. Set ch_in[0]=1 before the pre-fill completes, then hold it -> no trigger. Toggle 0->1 after pre-fill -> triggered=1 on that strobe.
- sample_div=3 with ch_in changing every clock -> consecutive stored samples are 4 clocks apart. Count clocks from the trigger to DONE = (DEPTH-PRE-1)*4 plus at most 1.
- PRE=0 and mode 00 -> trigger on the first strobe. The first popped sample is the first synchronized input after arm. Check the PRE=DEPTH-1 build also reaches DONE directly from ARMED.
- abort during POST, and separately after 3 pops in DONE -> IDLE next cycle, rd_valid=0, triggered=0. abort+arm in the same cycle from IDLE -> stays IDLE.
- Assert rst_n=0 mid-POST -> all outputs return to their reset values immediately. A new arm after release performs a full capture correctly.
